// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared types, register offsets and address decode for the GPIO register block
package axil_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  localparam logic [31:0] REG_LED      = 32'h00;
  localparam logic [31:0] REG_SCRATCH  = 32'h04;
  localparam logic [31:0] REG_CYCLES   = 32'h08;
  localparam logic [31:0] REG_IRQ_STAT = 32'h0C;
  localparam logic [31:0] REG_IRQ_EN   = 32'h10;
  localparam logic [31:0] REG_ID       = 32'h14;

  typedef enum logic [2:0] {
    SEL_LED,
    SEL_SCRATCH,
    SEL_CYCLES,
    SEL_IRQ_STAT,
    SEL_IRQ_EN,
    SEL_ID
  } reg_sel_t;

  typedef struct packed {
    reg_sel_t sel;
    logic     valid;
  } decode_t;

  // Word-aligned decode; the two byte-offset bits never select a register.
  function automatic decode_t decode(input logic [31:0] addr);
    decode_t     d;
    logic [31:0] word;
    word    = addr & ~32'h3;
    d.sel   = SEL_LED;
    d.valid = 1'b1;
    case (word)
      REG_LED:      d.sel = SEL_LED;
      REG_SCRATCH:  d.sel = SEL_SCRATCH;
      REG_CYCLES:   d.sel = SEL_CYCLES;
      REG_IRQ_STAT: d.sel = SEL_IRQ_STAT;
      REG_IRQ_EN:   d.sel = SEL_IRQ_EN;
      REG_ID:       d.sel = SEL_ID;
      default:      d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/axil_gpio_regs_if.sv
// rtl/axil_gpio_regs_if.sv - AXI4-Lite bus bundle with master and slave views
interface axil_gpio_regs_if #(
  parameter int ADDR_W = 6
);
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_slot.sv
// rtl/axil_slot.sv - one-entry holding buffer for a write address or write data beat
module axil_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic [W-1:0] data,
  output logic         full,
  input  logic         clear
);

  // Ready is held low during reset so nothing is accepted into a slot being discarded.
  assign in_ready = !full && !rst;

  // Fill on handshake, empty when the commit consumes the entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      data <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (in_valid && in_ready) begin
      full <= 1'b1;
      data <= in_data;
    end
  end

endmodule

// File: rtl/axil_gpio_regs.sv
// rtl/axil_gpio_regs.sv - AXI4-Lite register block: LEDs, scratch, cycle counter, sticky irq capture
module axil_gpio_regs
  import axil_pkg::*;
#(
  parameter int          ADDR_W   = 6,
  parameter int          IRQ_W    = 4,
  parameter logic [31:0] ID_VALUE = 32'hA57E_0001
) (
  input  logic                 clk,
  input  logic                 rst,
  axil_gpio_regs_if.slave      s_axi,
  input  logic [IRQ_W-1:0]     irq_in,
  output logic [3:0]           led,
  output logic                 irq
);

  logic              aw_ready;
  logic              w_ready;
  logic              aw_full;
  logic              w_full;
  logic              commit;
  logic [ADDR_W-1:0] aw_addr;
  logic [35:0]       w_slot;
  logic [31:0]       wr_data;
  logic [3:0]        wr_strb;
  logic [31:0]       aw_ext;
  logic [31:0]       ar_ext;
  decode_t           wr_dec;
  decode_t           rd_dec;

  logic [31:0]       scratch;
  logic [31:0]       cycle_cnt;
  logic [IRQ_W-1:0]  irq_stat;
  logic [IRQ_W-1:0]  irq_en;
  logic [IRQ_W-1:0]  irq_prev;
  logic [IRQ_W-1:0]  w1c_mask;
  logic [31:0]       rd_data;
  resp_t             rd_resp;
  logic              ar_hs;

  axil_slot #(.W(ADDR_W)) u_aw_slot (
    .clk      (clk),
    .rst      (rst),
    .in_valid (s_axi.awvalid),
    .in_ready (aw_ready),
    .in_data  (s_axi.awaddr),
    .data     (aw_addr),
    .full     (aw_full),
    .clear    (commit)
  );

  axil_slot #(.W(36)) u_w_slot (
    .clk      (clk),
    .rst      (rst),
    .in_valid (s_axi.wvalid),
    .in_ready (w_ready),
    .in_data  ({s_axi.wstrb, s_axi.wdata}),
    .data     (w_slot),
    .full     (w_full),
    .clear    (commit)
  );

  assign s_axi.awready = aw_ready;
  assign s_axi.wready  = w_ready;
  assign {wr_strb, wr_data} = w_slot;

  // A write retires once both halves are present and the B channel has room.
  assign commit = aw_full && w_full && (!s_axi.bvalid || s_axi.bready);

  // Only one read may be outstanding; nothing is accepted during reset.
  assign s_axi.arready = !s_axi.rvalid && !rst;
  assign ar_hs         = s_axi.arvalid && s_axi.arready;

  // Zero-extend the decoded address bits before handing them to the shared decoder.
  always_comb begin
    aw_ext = '0;
    ar_ext = '0;
    aw_ext[ADDR_W-1:0] = aw_addr;
    ar_ext[ADDR_W-1:0] = s_axi.araddr;
  end

  assign wr_dec = decode(aw_ext);
  assign rd_dec = decode(ar_ext);

  // Bits to clear in IRQ_STAT from a committed write-one-to-clear.
  always_comb begin
    w1c_mask = '0;
    if (commit && wr_dec.valid && wr_dec.sel == SEL_IRQ_STAT && wr_strb[0]) begin
      w1c_mask = wr_data[IRQ_W-1:0];
    end
  end

  // Register bank, free-running counter, edge capture and the registered irq level.
  always_ff @(posedge clk) begin
    if (rst) begin
      led       <= '0;
      scratch   <= '0;
      cycle_cnt <= '0;
      irq_stat  <= '0;
      irq_en    <= '0;
      irq_prev  <= '0;
      irq       <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      irq_prev  <= irq_in;
      // A rising edge in the same cycle as a clear keeps the bit set.
      irq_stat  <= (irq_stat & ~w1c_mask) | (irq_in & ~irq_prev);
      irq       <= |(irq_stat & irq_en);
      if (commit && wr_dec.valid) begin
        case (wr_dec.sel)
          SEL_LED: begin
            if (wr_strb[0]) led <= wr_data[3:0];
          end
          SEL_SCRATCH: begin
            for (int i = 0; i < 4; i++) begin
              if (wr_strb[i]) scratch[8*i +: 8] <= wr_data[8*i +: 8];
            end
          end
          SEL_IRQ_EN: begin
            if (wr_strb[0]) irq_en <= wr_data[IRQ_W-1:0];
          end
          default: ;
        endcase
      end
    end
  end

  // Read mux sampled at the AR handshake, so a same-cycle commit is not yet visible.
  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    if (!rd_dec.valid) begin
      rd_resp = RESP_SLVERR;
    end else begin
      case (rd_dec.sel)
        SEL_LED:      rd_data = {28'd0, led};
        SEL_SCRATCH:  rd_data = scratch;
        SEL_CYCLES:   rd_data = cycle_cnt;
        SEL_IRQ_STAT: rd_data = {{(32-IRQ_W){1'b0}}, irq_stat};
        SEL_IRQ_EN:   rd_data = {{(32-IRQ_W){1'b0}}, irq_en};
        SEL_ID:       rd_data = ID_VALUE;
        default:      rd_data = '0;
      endcase
    end
  end

  // Write response register: loaded by commit, held until the master takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_axi.bvalid <= 1'b0;
      s_axi.bresp  <= RESP_OKAY;
    end else if (commit) begin
      s_axi.bvalid <= 1'b1;
      s_axi.bresp  <= wr_dec.valid ? RESP_OKAY : RESP_SLVERR;
    end else if (s_axi.bready) begin
      s_axi.bvalid <= 1'b0;
    end
  end

  // Read response register: captured on AR handshake, held until the master takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_axi.rvalid <= 1'b0;
      s_axi.rdata  <= '0;
      s_axi.rresp  <= RESP_OKAY;
    end else if (ar_hs) begin
      s_axi.rvalid <= 1'b1;
      s_axi.rdata  <= rd_data;
      s_axi.rresp  <= rd_resp;
    end else if (s_axi.rready) begin
      s_axi.rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axil_gpio_regs.sv
// tb/tb_axil_gpio_regs.sv - directed and randomized self-checking bench for axil_gpio_regs
module tb_axil_gpio_regs;

  localparam logic [31:0] ID = 32'hA57E_0001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] irq_in = 4'd0;
  logic [3:0] led;
  logic       irq;

  int checks = 0;
  int errors = 0;
  int tb_cyc = 0;
  int rd_hs_cyc = 0;

  logic [3:0]  m_led;
  logic [31:0] m_scratch;
  logic [3:0]  m_stat;
  logic [3:0]  m_en;

  logic [31:0] addrs [7] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h3C};

  axil_gpio_regs_if #(.ADDR_W(6)) bus ();

  axil_gpio_regs #(.ADDR_W(6), .IRQ_W(4), .ID_VALUE(ID)) dut (
    .clk    (clk),
    .rst    (rst),
    .s_axi  (bus),
    .irq_in (irq_in),
    .led    (led),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model of the register map, written from the register rules.
  task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         output logic [1:0] r);
    r = 2'b00;
    case (a & ~32'h3)
      32'h00: if (s[0]) m_led = d[3:0];
      32'h04: for (int i = 0; i < 4; i++) if (s[i]) m_scratch[8*i +: 8] = d[8*i +: 8];
      32'h08, 32'h14: ;
      32'h0C: if (s[0]) m_stat = m_stat & ~d[3:0];
      32'h10: if (s[0]) m_en = d[3:0];
      default: r = 2'b10;
    endcase
  endtask

  task automatic m_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
    r = 2'b00;
    d = 32'd0;
    case (a & ~32'h3)
      32'h00: d = {28'd0, m_led};
      32'h04: d = m_scratch;
      32'h0C: d = {28'd0, m_stat};
      32'h10: d = {28'd0, m_en};
      32'h14: d = ID;
      default: r = 2'b10;
    endcase
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int n;
    bit aw_done, w_done, aw_hs, w_hs;
    bus.awaddr  = a[5:0];
    bus.wdata   = d;
    bus.wstrb   = s;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    bus.bready  = 1'b1;
    aw_done = 0;
    w_done  = 0;
    n = 0;
    while (!(aw_done && w_done) && n < 20) begin
      aw_hs = bus.awvalid && bus.awready;
      w_hs  = bus.wvalid && bus.wready;
      tick();
      n++;
      if (aw_hs) begin bus.awvalid = 1'b0; aw_done = 1; end
      if (w_hs)  begin bus.wvalid  = 1'b0; w_done  = 1; end
    end
    check("wr_handshake_timeout", 32'(aw_done && w_done), 32'd1);
    n = 0;
    while (!bus.bvalid && n < 20) begin
      tick();
      n++;
    end
    check("wr_bvalid_timeout", 32'(bus.bvalid), 32'd1);
    resp = bus.bresp;
    tick();
    bus.bready  = 1'b0;
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    bit done, hs;
    bus.araddr  = a[5:0];
    bus.arvalid = 1'b1;
    bus.rready  = 1'b1;
    done = 0;
    n = 0;
    while (!done && n < 20) begin
      hs = bus.arready;
      tick();
      n++;
      if (hs) begin
        done = 1;
        bus.arvalid = 1'b0;
        rd_hs_cyc = tb_cyc;
      end
    end
    bus.arvalid = 1'b0;
    check("rd_rvalid_timeout", 32'(bus.rvalid), 32'd1);
    d    = bus.rdata;
    resp = bus.rresp;
    tick();
    bus.rready = 1'b0;
  endtask

  initial begin
    logic [31:0] rd, ed, c1, c2, a, d;
    logic [1:0]  rs, er, er2;
    logic [3:0]  s;
    int          t1, t2;

    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    m_led = 4'd0; m_scratch = 32'd0; m_stat = 4'd0; m_en = 4'd0;

    // 1: reset state, then AW+W together
    rst = 1'b1;
    tick(); tick();
    check("rst_awready", 32'(bus.awready), 32'd0);
    check("rst_wready", 32'(bus.wready), 32'd0);
    check("rst_arready", 32'(bus.arready), 32'd0);
    check("rst_bvalid", 32'(bus.bvalid), 32'd0);
    check("rst_rvalid", 32'(bus.rvalid), 32'd0);
    check("rst_bresp", 32'(bus.bresp), 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_led", 32'(led), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    rst = 1'b0;
    tick();
    check("t1_awready", 32'(bus.awready), 32'd1);
    check("t1_wready", 32'(bus.wready), 32'd1);
    bus.awaddr = 6'h00; bus.wdata = 32'h0000_000A; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    check("t1_bvalid_not_yet", 32'(bus.bvalid), 32'd0);
    tick();
    check("t1_bvalid", 32'(bus.bvalid), 32'd1);
    check("t1_bresp", 32'(bus.bresp), 32'd0);
    check("t1_led", 32'(led), 32'hA);
    m_led = 4'hA;
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    check("t1_bvalid_drop", 32'(bus.bvalid), 32'd0);

    // 2: W ahead of AW, then a strobed scratch write
    bus.awaddr = 6'h04; bus.wdata = 32'hDEAD_BEEF; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    tick();
    bus.wvalid = 1'b0;
    check("t2_wready_full", 32'(bus.wready), 32'd0);
    check("t2_awready_empty", 32'(bus.awready), 32'd1);
    tick(); tick();
    check("t2_no_commit_without_aw", 32'(bus.bvalid), 32'd0);
    bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    check("t2_awready_full", 32'(bus.awready), 32'd0);
    tick();
    check("t2_bvalid", 32'(bus.bvalid), 32'd1);
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    m_scratch = 32'hDEAD_BEEF;
    axi_write(32'h04, 32'h1122_3344, 4'b0101, rs);
    m_write(32'h04, 32'h1122_3344, 4'b0101, er);
    check("t2_strb_bresp", 32'(rs), 32'(er));
    axi_read(32'h04, rd, rs);
    check("t2_scratch_strb", rd, 32'hDE22_BE44);
    check("t2_scratch_model", rd, m_scratch);

    // 3: B stalled, second commit waits, then back-to-back B
    bus.bready = 1'b0;
    bus.awaddr = 6'h00; bus.wdata = 32'h3; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    tick();
    check("t3_first_bvalid", 32'(bus.bvalid), 32'd1);
    check("t3_led_first", 32'(led), 32'h3);
    bus.wdata = 32'h5;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    tick();
    check("t3_awready_stall", 32'(bus.awready), 32'd0);
    check("t3_wready_stall", 32'(bus.wready), 32'd0);
    check("t3_led_stalled", 32'(led), 32'h3);
    bus.bready = 1'b1;
    tick();
    check("t3_b_back_to_back", 32'(bus.bvalid), 32'd1);
    check("t3_led_second", 32'(led), 32'h5);
    tick();
    check("t3_b_done", 32'(bus.bvalid), 32'd0);
    bus.bready = 1'b0;
    m_led = 4'h5;

    // 4: irq capture, set-beats-clear, plain clear
    axi_write(32'h10, 32'h4, 4'hF, rs);
    m_write(32'h10, 32'h4, 4'hF, er);
    irq_in = 4'b0100;
    tick(); tick();
    m_stat = 4'h4;
    check("t4_irq_set", 32'(irq), 32'd1);
    axi_read(32'h0C, rd, rs);
    check("t4_stat", rd, 32'h4);
    irq_in = 4'b0000;
    tick();
    bus.awaddr = 6'h0C; bus.wdata = 32'h4; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    irq_in = 4'b0100;
    tick();
    tick();
    bus.bready = 1'b0;
    axi_read(32'h0C, rd, rs);
    check("t4_set_wins", rd, 32'h4);
    check("t4_irq_still", 32'(irq), 32'd1);
    axi_write(32'h0C, 32'h4, 4'hF, rs);
    m_write(32'h0C, 32'h4, 4'hF, er);
    tick(); tick();
    check("t4_irq_cleared", 32'(irq), 32'd0);
    axi_read(32'h0C, rd, rs);
    check("t4_stat_cleared", rd, {28'd0, m_stat});

    // 5: ID, unmapped read and write
    axi_read(32'h14, rd, rs);
    check("t5_id", rd, ID);
    check("t5_id_resp", 32'(rs), 32'd0);
    axi_read(32'h20, rd, rs);
    check("t5_bad_rdata", rd, 32'd0);
    check("t5_bad_rresp", 32'(rs), 32'd2);
    axi_read(32'h18, rd, rs);
    check("t5_above_id_rresp", 32'(rs), 32'd2);
    axi_write(32'h20, 32'hFFFF_FFFF, 4'hF, rs);
    check("t5_bad_bresp", 32'(rs), 32'd2);
    axi_read(32'h00, rd, rs);
    check("t5_led_kept", rd, {28'd0, m_led});
    axi_read(32'h04, rd, rs);
    check("t5_scratch_kept", rd, m_scratch);
    axi_read(32'h10, rd, rs);
    check("t5_irq_en_kept", rd, {28'd0, m_en});

    // randomized writes and read-back against the model
    for (int k = 0; k < 24; k++) begin
      a = addrs[$urandom_range(0, 6)] | 32'($urandom_range(0, 3));
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      axi_write(a, d, s, rs);
      m_write(a, d, s, er);
      check("rnd_bresp", 32'(rs), 32'(er));
      if ((a & ~32'h3) != 32'h08) begin
        axi_read(a, rd, rs);
        m_read(a, ed, er2);
        check("rnd_rdata", rd, ed);
        check("rnd_rresp", 32'(rs), 32'(er2));
      end
    end
    check("rnd_led_pins", 32'(led), {28'd0, m_led});
    check("rnd_irq_low", 32'(irq), 32'd0);

    // 6: counter distance, then reset during a pending read
    axi_read(32'h08, c1, rs);
    t1 = rd_hs_cyc;
    repeat ($urandom_range(1, 10)) tick();
    axi_read(32'h08, c2, rs);
    t2 = rd_hs_cyc;
    check("t6_cycle_delta", c2 - c1, 32'(t2 - t1));
    bus.araddr = 6'h08; bus.arvalid = 1'b1; bus.rready = 1'b0;
    tick();
    bus.arvalid = 1'b0;
    check("t6_rvalid_pending", 32'(bus.rvalid), 32'd1);
    rst = 1'b1;
    tick();
    check("t6_rvalid_dropped", 32'(bus.rvalid), 32'd0);
    check("t6_arready_in_rst", 32'(bus.arready), 32'd0);
    check("t6_led_reset", 32'(led), 32'd0);
    rst = 1'b0;
    bus.arvalid = 1'b1; bus.rready = 1'b1;
    tick();
    bus.arvalid = 1'b0;
    check("t6_rvalid_after_rst", 32'(bus.rvalid), 32'd1);
    check("t6_counter_zero", bus.rdata, 32'd0);
    tick();
    bus.rready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
